regdest_pipe: RTL and testbench
===============================

# regdest_pipe

Carries destination-register tags for the EX, MEM and WB stages of the pipelined CPU, detects load-use hazards and inserts bubbles. Supplies the `MemRegWrite`/`MEMWriteReg` and `WbRegWrite`/`WBWriteReg` signals that the forwarding logic consumes. Handles branch flush and data-memory wait freeze. Also counts hazard stall cycles for performance monitoring.

## Interface
Parameters:
- `STALL_CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ID_rs`  in  5  rs address of the instruction in ID.
- `ID_rt`  in  5  rt address of the instruction in ID.
- `ID_uses_rt`  in  1  1 = the ID instruction reads rt as a source.
- `ID_WriteReg`  in  5  destination register of the ID instruction.
- `ID_RegWrite`  in  1  the ID instruction writes the register file.
- `ID_MemRead`  in  1  the ID instruction is a load.
- `flush`  in  1  branch taken in EX; the ID instruction is wrong-path.
- `mem_wait`  in  1  data memory not ready; freeze the pipeline.
- `stall`  out  1  hold PC and IF/ID (combinational).
- `EX_WriteReg`  out  5  ID/EX destination tag.
- `EX_RegWrite`  out  1  ID/EX register-write enable.
- `EX_MemRead`  out  1  ID/EX load flag.
- `MEMWriteReg`  out  5  EX/MEM destination tag.
- `MemRegWrite`  out  1  EX/MEM register-write enable.
- `MEMMemRead`  out  1  EX/MEM load flag.
- `WBWriteReg`  out  5  MEM/WB destination tag.
- `WbRegWrite`  out  1  MEM/WB register-write enable.
- `stall_count`  out  STALL_CNT_W  load-use stall cycles, saturating.

## Operation
- **Tag normalisation at ID/EX load:** if `ID_RegWrite=0` or `ID_WriteReg=0`, load tag 0 and `RegWrite` 0. `MemRead` passes unchanged.
- **Bubble:** `WriteReg=0`, `RegWrite=0`, `MemRead=0`.
- **Hazard term:** `hz = EX_MemRead & (EX_WriteReg!=0) & (EX_WriteReg==ID_rs | (ID_uses_rt & EX_WriteReg==ID_rt))`.
- **Stall output:** `stall = mem_wait | (hz & ~flush)`.
- **Per-edge update, in priority order:**
  1. `mem_wait=1`: all three stage registers and `stall_count` hold.
  2. Otherwise, `flush=1`: bubble into ID/EX. EX→MEM and MEM→WB advance.
  3. Otherwise, `hz=1`: bubble into ID/EX, EX→MEM and MEM→WB advance, `stall_count` increments.
  4. Otherwise: normalised ID fields into ID/EX, EX→MEM and MEM→WB advance.
- **Counter:** `stall_count` saturates at all-ones and never wraps.
- **Stage advance** copies all fields: `EX_*` → `MEM*`, and `MEMWriteReg`/`MemRegWrite` → `WB*`.
- **Stall release:** after one bubble the load is in MEM, so `hz` deasserts and the stalled instruction enters EX on the next edge. Forwarding then covers the dependency from MEM/WB.

## Timing
- **Reset:** while `reset`=1, all registered outputs = 0 (tags 0, enables 0, `stall_count` 0). This is asynchronous and applies mid-operation, mid-stall or during a freeze. After release, the first edge loads ID normally.
- **Combinational path:** `stall` depends on current-cycle ID inputs, ID/EX registers, `flush` and `mem_wait`. No register sits in this path.
- **Stage latency:** 1 cycle per stage; an ID tag appears at WB 3 edges after entry, absent freeze.
- **Load-use:** a load followed by a dependent instruction costs exactly 1 stall cycle. A dependency at distance 2 or more gives `stall=0`.
- **Freeze:** a `mem_wait` freeze of N cycles stretches every stage by N. `stall_count` does not count freeze cycles.
- **Flush with hazard:** when `flush` and `hz` coincide, `stall`=0 (unless `mem_wait`) and the counter does not increment.

## Test plan
- **Reset:** assert `reset` asynchronously mid-stall with `stall_count`=3. All outputs go to 0 immediately, before any clock edge.
- **Load-use on rs:** load `$5` (`ID_MemRead`=1, `ID_WriteReg`=5, `RegWrite`=1), then `ID_rs`=5.
  - `stall`=1 for exactly one cycle; a bubble is seen at EX; `stall_count`=1.
  - `MEMWriteReg`=5 with `MemRegWrite`=1 one cycle after the bubble; `WBWriteReg`=5 the cycle after that.
- **rt gating:** load `$7`, then `ID_rt`=7.
  - With `ID_uses_rt`=0: `stall`=0.
  - With `ID_uses_rt`=1: `stall`=1.
  - A load to `$0` followed by `ID_rs`=0: `stall`=0 and `EX_RegWrite`=0.
- **Flush:** `hz`=1 and `flush`=1 in the same cycle → `stall`=0, EX gets a bubble, `stall_count` unchanged.
- **Freeze:** `mem_wait`=1 for 3 cycles with tags 4/9/2 in EX/MEM/WB. `stall`=1 and all tags hold for 3 cycles, then advance on the first edge after release.
- **Saturation:** with `STALL_CNT_W`=2, 5 back-to-back load-use pairs leave `stall_count`=3.

Source files
------------

// File: rtl/regdest_pipe.sv
// Destination-tag pipeline (ID/EX, EX/MEM, MEM/WB) for the CPU: load-use
// hazard detection, bubble insertion, branch flush, memory-wait freeze, stall counter.
module regdest_pipe #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             ID_rs,
  input  logic [4:0]             ID_rt,
  input  logic                   ID_uses_rt,
  input  logic [4:0]             ID_WriteReg,
  input  logic                   ID_RegWrite,
  input  logic                   ID_MemRead,
  input  logic                   flush,
  input  logic                   mem_wait,
  output logic                   stall,
  output logic [4:0]             EX_WriteReg,
  output logic                   EX_RegWrite,
  output logic                   EX_MemRead,
  output logic [4:0]             MEMWriteReg,
  output logic                   MemRegWrite,
  output logic                   MEMMemRead,
  output logic [4:0]             WBWriteReg,
  output logic                   WbRegWrite,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic hz;
  logic id_writes;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; $0 never creates a dependency.
  always_comb begin
    hz = EX_MemRead && (EX_WriteReg != 5'd0) &&
         ((EX_WriteReg == ID_rs) || (ID_uses_rt && (EX_WriteReg == ID_rt)));
    stall = mem_wait || (hz && !flush);
    id_writes = ID_RegWrite && (ID_WriteReg != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_WriteReg <= 5'd0;
      EX_RegWrite <= 1'b0;
      EX_MemRead  <= 1'b0;
      MEMWriteReg <= 5'd0;
      MemRegWrite <= 1'b0;
      MEMMemRead  <= 1'b0;
      WBWriteReg  <= 5'd0;
      WbRegWrite  <= 1'b0;
      stall_count <= '0;
    end else if (!mem_wait) begin
      MEMWriteReg <= EX_WriteReg;
      MemRegWrite <= EX_RegWrite;
      MEMMemRead  <= EX_MemRead;
      WBWriteReg  <= MEMWriteReg;
      WbRegWrite  <= MemRegWrite;
      if (flush || hz) begin
        EX_WriteReg <= 5'd0;
        EX_RegWrite <= 1'b0;
        EX_MemRead  <= 1'b0;
        // Only genuine load-use bubbles are counted; a flush wins over a hazard.
        if (!flush && (stall_count != '1))
          stall_count <= stall_count + STALL_CNT_W'(1);
      end else begin
        EX_WriteReg <= id_writes ? ID_WriteReg : 5'd0;
        EX_RegWrite <= id_writes;
        EX_MemRead  <= ID_MemRead;
      end
    end
  end

endmodule

// File: tb/tb_regdest_pipe.sv
// Scoreboard bench for regdest_pipe: directed vectors push hand-computed
// expectations; a monitor pops and compares once per cycle or on demand.
module tb_regdest_pipe;

  typedef struct {
    string      tag;
    logic       stall;
    logic [4:0] ex_w;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_w;
    logic       mem_rw;
    logic       mem_mr;
    logic [4:0] wb_w;
    logic       wb_rw;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_write_reg = '0;
  logic       id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       flush = 1'b0, mem_wait = 1'b0;

  logic        stall, ex_rw, ex_mr, mem_rw, mem_mr, wb_rw;
  logic [4:0]  ex_w, mem_w, wb_w;
  logic [15:0] stall_count;

  logic        stall2, ex_rw2, ex_mr2, mem_rw2, mem_mr2, wb_rw2;
  logic [4:0]  ex_w2, mem_w2, wb_w2;
  logic [1:0]  stall_count2;

  exp_t sb[$];
  event sample_ev;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regdest_pipe #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_WriteReg(id_write_reg), .ID_RegWrite(id_reg_write), .ID_MemRead(id_mem_read),
    .flush(flush), .mem_wait(mem_wait), .stall(stall),
    .EX_WriteReg(ex_w), .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr),
    .MEMWriteReg(mem_w), .MemRegWrite(mem_rw), .MEMMemRead(mem_mr),
    .WBWriteReg(wb_w), .WbRegWrite(wb_rw), .stall_count(stall_count)
  );

  // Narrow-counter copy on the same inputs exercises saturation.
  regdest_pipe #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_WriteReg(id_write_reg), .ID_RegWrite(id_reg_write), .ID_MemRead(id_mem_read),
    .flush(flush), .mem_wait(mem_wait), .stall(stall2),
    .EX_WriteReg(ex_w2), .EX_RegWrite(ex_rw2), .EX_MemRead(ex_mr2),
    .MEMWriteReg(mem_w2), .MemRegWrite(mem_rw2), .MEMMemRead(mem_mr2),
    .WBWriteReg(wb_w2), .WbRegWrite(wb_rw2), .stall_count(stall_count2)
  );

  function automatic exp_t mk(input string tag, input logic st,
                              input logic [4:0] ew, input logic erw, input logic emr,
                              input logic [4:0] mw, input logic mrw, input logic mmr,
                              input logic [4:0] ww, input logic wrw, input int cnt);
    exp_t e;
    e.tag = tag; e.stall = st;
    e.ex_w = ew; e.ex_rw = erw; e.ex_mr = emr;
    e.mem_w = mw; e.mem_rw = mrw; e.mem_mr = mmr;
    e.wb_w = ww; e.wb_rw = wrw; e.cnt = cnt;
    return e;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic [4:0] wr, input logic rw, input logic mr,
                               input logic fl, input logic mw, input exp_t e);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = ur;
    id_write_reg = wr; id_reg_write = rw; id_mem_read = mr;
    flush = fl; mem_wait = mw;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk({e.tag, "/stall"}, 32'(stall), 32'(e.stall));
    chk({e.tag, "/ex_w"}, 32'(ex_w), 32'(e.ex_w));
    chk({e.tag, "/ex_rw"}, 32'(ex_rw), 32'(e.ex_rw));
    chk({e.tag, "/ex_mr"}, 32'(ex_mr), 32'(e.ex_mr));
    chk({e.tag, "/mem_w"}, 32'(mem_w), 32'(e.mem_w));
    chk({e.tag, "/mem_rw"}, 32'(mem_rw), 32'(e.mem_rw));
    chk({e.tag, "/mem_mr"}, 32'(mem_mr), 32'(e.mem_mr));
    chk({e.tag, "/wb_w"}, 32'(wb_w), 32'(e.wb_w));
    chk({e.tag, "/wb_rw"}, 32'(wb_rw), 32'(e.wb_rw));
    chk({e.tag, "/count"}, 32'(stall_count), 32'(e.cnt));
    chk({e.tag, "/count_sat"}, 32'(stall_count2), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
  endtask

  // Monitor: one expectation per cycle, plus on-demand samples between edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, mk("reset", 0, 0,0,0, 0,0,0, 0,0, 0));
    @(negedge clk);
    #1 reset = 1'b0;

    applyStimulus(1, 2, 1, 5, 1, 1, 0, 0, mk("ld5",        0, 0,0,0, 0,0,0, 0,0, 0));
    applyStimulus(5, 0, 0, 6, 1, 0, 0, 0, mk("use_rs",     1, 5,1,1, 0,0,0, 0,0, 0));
    applyStimulus(5, 0, 0, 6, 1, 0, 0, 0, mk("bubble",     0, 0,0,0, 5,1,1, 0,0, 1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, mk("ld5_wb",     0, 6,1,0, 0,0,0, 5,1, 1));
    applyStimulus(1, 2, 1, 7, 1, 1, 0, 0, mk("ld7",        0, 0,0,0, 6,1,0, 0,0, 1));
    applyStimulus(3, 7, 0, 8, 1, 0, 0, 0, mk("rt_unused",  0, 7,1,1, 0,0,0, 6,1, 1));
    applyStimulus(0, 0, 0, 7, 1, 1, 0, 0, mk("ld7b",       0, 8,1,0, 7,1,1, 0,0, 1));
    applyStimulus(3, 7, 1, 9, 1, 0, 0, 0, mk("rt_used",    1, 7,1,1, 8,1,0, 7,1, 1));
    applyStimulus(3, 7, 1, 9, 1, 0, 0, 0, mk("rt_release", 0, 0,0,0, 7,1,1, 8,1, 2));
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, mk("ld0",        0, 9,1,0, 0,0,0, 7,1, 2));
    applyStimulus(0, 0, 1, 3, 1, 0, 0, 0, mk("use0",       0, 0,0,1, 9,1,0, 0,0, 2));
    applyStimulus(0, 0, 0, 4, 0, 0, 0, 0, mk("rw_off",     0, 3,1,0, 0,0,1, 9,1, 2));
    applyStimulus(0, 0, 0, 5, 1, 1, 0, 0, mk("ld5_fl",     0, 0,0,0, 3,1,0, 0,0, 2));
    applyStimulus(5, 0, 0, 6, 1, 0, 1, 0, mk("flush_hz",   0, 5,1,1, 0,0,0, 3,1, 2));
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 0, mk("post_flush", 0, 0,0,0, 5,1,1, 0,0, 2));
    applyStimulus(0, 0, 0, 2, 1, 0, 0, 0, mk("tag2",       0, 0,0,0, 0,0,0, 5,1, 2));
    applyStimulus(0, 0, 0, 9, 1, 0, 0, 0, mk("tag9",       0, 2,1,0, 0,0,0, 0,0, 2));
    applyStimulus(0, 0, 0, 4, 1, 1, 0, 0, mk("tag4",       0, 9,1,0, 2,1,0, 0,0, 2));
    for (int i = 0; i < 3; i++)
      applyStimulus(4, 0, 0, 5, 1, 0, 0, 1, mk("freeze",   1, 4,1,1, 9,1,0, 2,1, 2));
    applyStimulus(4, 0, 0, 5, 1, 0, 0, 0, mk("unfreeze",   1, 4,1,1, 9,1,0, 2,1, 2));
    applyStimulus(4, 0, 0, 5, 1, 0, 0, 0, mk("advance",    0, 0,0,0, 4,1,1, 9,1, 3));

    applyStimulus(0, 0, 0, 10, 1, 1, 0, 0, mk("ld10",      0, 5,1,0, 0,0,0, 4,1, 3));
    applyStimulus(10, 0, 0, 0, 0, 0, 0, 0, mk("use10",     1, 10,1,1, 5,1,0, 0,0, 3));
    applyStimulus(10, 0, 0, 0, 0, 0, 0, 0, mk("rel10",     0, 0,0,0, 10,1,1, 5,1, 4));
    for (int k = 11; k <= 14; k++) begin
      applyStimulus(0, 0, 0, 5'(k), 1, 1, 0, 0, mk("sat_ld",  0, 0,0,0, 0,0,0, 5'(k-1),1, k-7));
      applyStimulus(5'(k), 0, 0, 0, 0, 0, 0, 0, mk("sat_use", 1, 5'(k),1,1, 0,0,0, 0,0, k-7));
      applyStimulus(5'(k), 0, 0, 0, 0, 0, 0, 0, mk("sat_rel", 0, 0,0,0, 5'(k),1,1, 0,0, k-6));
    end

    applyStimulus(0, 0, 0, 20, 1, 1, 0, 0, mk("ld20",      0, 0,0,0, 0,0,0, 14,1, 8));
    applyStimulus(20, 0, 0, 0, 0, 0, 0, 0, mk("use20",     1, 20,1,1, 0,0,0, 0,0, 8));
    // Reset lands between edges while the stall is showing.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 sb.push_back(mk("async_rst", 0, 0,0,0, 0,0,0, 0,0, 0));
    -> sample_ev;
    applyStimulus(20, 0, 0, 0, 0, 0, 0, 0, mk("in_reset",  0, 0,0,0, 0,0,0, 0,0, 0));
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(0, 0, 0, 3, 1, 1, 0, 0, mk("first_ld",   0, 0,0,0, 0,0,0, 0,0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, mk("first_ex",   0, 3,1,1, 0,0,0, 0,0, 0));

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
